timer_scheduler: RTL and testbench

- Controller that shares the single 4-bit countdown timer of the anti-theft system among up to three requesters: the arming FSM, the door-delay logic and the siren on-time logic.
- Owns the four-entry time-parameter table, with reprogramming through time_param_sel, time_value and reprogram.
- Queues timer requests and grants the timer round-robin.
- Counts down on one_hz_enable and returns a one-cycle expiry pulse to the requester that owned the timer.

---
 rtl/timer_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_timer_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// timer_scheduler: shares one 4-bit countdown timer among three requesters,
// owns the reprogrammable interval table and arbitrates round-robin.
module timer_scheduler #(
  parameter int unsigned T_ARM_DELAY       = 6,
  parameter int unsigned T_DRIVER_DELAY    = 8,
  parameter int unsigned T_PASSENGER_DELAY = 15,
  parameter int unsigned T_ALARM_ON        = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [5:0] req_interval,
  input  logic [2:0] cancel,
  input  logic       one_hz_enable,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic [2:0] grant,
  output logic [2:0] expired,
  output logic       busy,
  output logic [3:0] timer_count,
  output logic [1:0] active_interval
);

  localparam int unsigned NREQ = 3;
  localparam int unsigned CW   = 4;
  localparam int unsigned IW   = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [1:0]           owner_q, owner_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [NREQ-1:0]      pend_q, pend_d;
  logic [NREQ*IW-1:0]   pend_int_q, pend_int_d;
  logic [3:0][CW-1:0]   tbl_q, tbl_d;
  logic                 reprog_q;
  logic [CW-1:0]        count_q, count_d;
  logic [IW-1:0]        active_q, active_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      expired_q, expired_d;
  logic                 busy_q, busy_d;

  logic                 owned;
  logic                 req_own, can_own;
  logic [IW-1:0]        int_own;
  logic                 pick_valid;
  logic [1:0]           pick_idx;
  logic [IW-1:0]        pick_int;
  logic [2:0]           cand3;

  function automatic logic [CW-1:0] tbl_default(input logic [1:0] sel);
    case (sel)
      2'd0:    tbl_default = CW'(T_ARM_DELAY);
      2'd1:    tbl_default = CW'(T_DRIVER_DELAY);
      2'd2:    tbl_default = CW'(T_PASSENGER_DELAY);
      default: tbl_default = CW'(T_ALARM_ON);
    endcase
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] o);
    next_idx = (o == 2'd2) ? 2'd0 : o + 2'd1;
  endfunction

  // Owner-side request/cancel view and round-robin pick among pending flags
  always_comb begin
    owned      = (state_q == S_LOAD) || (state_q == S_RUN);
    req_own    = 1'b0;
    can_own    = 1'b0;
    int_own    = '0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_int   = '0;
    cand3      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == 2'(i)) begin
        req_own = req[i];
        can_own = cancel[i];
        int_own = req_interval[i*IW +: IW];
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      cand3 = {1'b0, ptr_q} + 3'(k);
      if (cand3 >= 3'(NREQ)) cand3 = cand3 - 3'(NREQ);
      if (!pick_valid && pend_q[cand3[1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand3[1:0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == 2'(i)) pick_int = pend_int_q[i*IW +: IW];
    end
  end

  // Next-state: FSM, pending queue, parameter table and registered outputs
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    pend_d     = pend_q;
    pend_int_d = pend_int_q;
    tbl_d      = tbl_q;
    count_d    = count_q;
    active_d   = active_q;
    grant_d    = grant_q;
    expired_d  = '0;
    busy_d     = busy_q;

    // Table write on reprogram rising edge; a LOAD this cycle reads tbl_q
    if (reprogram && !reprog_q) begin
      tbl_d[time_param_sel] = (time_value == '0) ? tbl_default(time_param_sel) : time_value;
    end

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d          = pick_idx;
          active_d         = pick_int;
          pend_d[pick_idx] = 1'b0;
          grant_d          = 3'b001 << pick_idx;
          busy_d           = 1'b1;
          state_d          = S_LOAD;
        end
      end
      S_LOAD, S_RUN: begin
        if (can_own) begin
          state_d = S_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
          ptr_d   = next_idx(owner_q);
        end else if (req_own) begin
          active_d = int_own;
          count_d  = tbl_q[int_own];
          state_d  = S_RUN;
        end else if (state_q == S_LOAD) begin
          count_d = tbl_q[active_q];
          state_d = S_RUN;
        end else if (one_hz_enable) begin
          if (count_q <= CW'(1)) begin
            count_d   = '0;
            state_d   = S_DONE;
            expired_d = grant_q;
            grant_d   = '0;
            busy_d    = 1'b0;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end
      S_DONE: begin
        ptr_d   = next_idx(owner_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pending flags: cancel beats req; the owner's own req is a restart instead
    for (int i = 0; i < NREQ; i++) begin
      if (cancel[i]) begin
        pend_d[i] = 1'b0;
      end else if (req[i] && !(owned && (owner_q == 2'(i)))) begin
        pend_d[i]                 = 1'b1;
        pend_int_d[i*IW +: IW]    = req_interval[i*IW +: IW];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      pend_q     <= '0;
      pend_int_q <= '0;
      for (int e = 0; e < 4; e++) tbl_q[e] <= tbl_default(2'(e));
      reprog_q   <= 1'b0;
      count_q    <= '0;
      active_q   <= '0;
      grant_q    <= '0;
      expired_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      pend_int_q <= pend_int_d;
      tbl_q      <= tbl_d;
      reprog_q   <= reprogram;
      count_q    <= count_d;
      active_q   <= active_d;
      grant_q    <= grant_d;
      expired_q  <= expired_d;
      busy_q     <= busy_d;
    end
  end

  assign grant           = grant_q;
  assign expired         = expired_q;
  assign busy            = busy_q;
  assign timer_count     = count_q;
  assign active_interval = active_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: one task per scenario, inline checks.
module tb_timer_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [5:0] req_interval;
  logic [2:0] cancel;
  logic       one_hz_enable;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic [2:0] grant;
  logic [2:0] expired;
  logic       busy;
  logic [3:0] timer_count;
  logic [1:0] active_interval;

  int checks = 0;
  int errors = 0;

  timer_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .req_interval   (req_interval),
    .cancel         (cancel),
    .one_hz_enable  (one_hz_enable),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .grant          (grant),
    .expired        (expired),
    .busy           (busy),
    .timer_count    (timer_count),
    .active_interval(active_interval)
  );

  always #5 clock = ~clock;

  // Advance one clock and land 1 time unit after the rising edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick();
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
  endtask

  task automatic pulse_req(input logic [2:0] r, input logic [5:0] iv);
    req = r;
    req_interval = iv;
    step();
    req = '0;
  endtask

  task automatic do_reprogram(input logic [1:0] sel, input logic [3:0] val);
    time_param_sel = sel;
    time_value = val;
    reprogram = 1'b1;
    step();
    reprogram = 1'b0;
    step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = '0; req_interval = '0; cancel = '0; one_hz_enable = 1'b0;
    reprogram = 1'b0; time_param_sel = '0; time_value = '0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rst_grant got=%b exp=%b", grant, 3'b000); end
    checks++; if (expired !== 3'b000) begin errors++; $display("FAIL rst_expired got=%b exp=%b", expired, 3'b000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=%b", busy, 1'b0); end
    checks++; if (timer_count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=%0d", timer_count, 0); end
    checks++; if (active_interval !== 2'd0) begin errors++; $display("FAIL rst_active got=%0d exp=%0d", active_interval, 0); end
  endtask

  task automatic test_basic_countdown();
    apply_reset();
    pulse_req(3'b001, 6'b00_00_00);
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL t1_grant_pending got=%b exp=%b", grant, 3'b000); end
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL t1_grant_load got=%b exp=%b", grant, 3'b001); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_load got=%b exp=%b", busy, 1'b1); end
    step();
    checks++; if (timer_count !== 4'd6) begin errors++; $display("FAIL t1_count_loaded got=%0d exp=%0d", timer_count, 6); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (timer_count !== 4'(6 - k)) begin errors++; $display("FAIL t1_count_tick%0d got=%0d exp=%0d", k, timer_count, 6 - k); end
      checks++; if (expired !== 3'b000) begin errors++; $display("FAIL t1_early_expiry%0d got=%b exp=%b", k, expired, 3'b000); end
    end
    tick();
    checks++; if (timer_count !== 4'd0) begin errors++; $display("FAIL t1_count_zero got=%0d exp=%0d", timer_count, 0); end
    checks++; if (expired !== 3'b001) begin errors++; $display("FAIL t1_expired got=%b exp=%b", expired, 3'b001); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL t1_grant_done got=%b exp=%b", grant, 3'b000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_done got=%b exp=%b", busy, 1'b0); end
    step();
    checks++; if (expired !== 3'b000) begin errors++; $display("FAIL t1_expired_width got=%b exp=%b", expired, 3'b000); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    pulse_req(3'b110, 6'b10_01_00);
    step();
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL t2_grant1 got=%b exp=%b", grant, 3'b010); end
    checks++; if (active_interval !== 2'd1) begin errors++; $display("FAIL t2_active1 got=%0d exp=%0d", active_interval, 1); end
    step();
    checks++; if (timer_count !== 4'd8) begin errors++; $display("FAIL t2_count1 got=%0d exp=%0d", timer_count, 8); end
    for (int k = 0; k < 8; k++) tick();
    checks++; if (expired !== 3'b010) begin errors++; $display("FAIL t2_expired1 got=%b exp=%b", expired, 3'b010); end
    step();
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL t2_gap_grant got=%b exp=%b", grant, 3'b000); end
    step();
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL t2_grant2 got=%b exp=%b", grant, 3'b100); end
    step();
    checks++; if (timer_count !== 4'd15) begin errors++; $display("FAIL t2_count2 got=%0d exp=%0d", timer_count, 15); end
    for (int k = 0; k < 15; k++) tick();
    checks++; if (expired !== 3'b100) begin errors++; $display("FAIL t2_expired2 got=%b exp=%b", expired, 3'b100); end
    step();
    // Pointer back at 0: requester 0 wins over requester 2
    pulse_req(3'b101, 6'b00_00_00);
    step();
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL t2_ptr_wrap got=%b exp=%b", grant, 3'b001); end
  endtask

  task automatic test_reprogram();
    apply_reset();
    do_reprogram(2'd3, 4'd4);
    pulse_req(3'b100, 6'b11_00_00);
    step();
    checks++; if (active_interval !== 2'd3) begin errors++; $display("FAIL t3_active got=%0d exp=%0d", active_interval, 3); end
    step();
    checks++; if (timer_count !== 4'd4) begin errors++; $display("FAIL t3_count_prog got=%0d exp=%0d", timer_count, 4); end
    for (int k = 0; k < 4; k++) tick();
    checks++; if (expired !== 3'b100) begin errors++; $display("FAIL t3_expired got=%b exp=%b", expired, 3'b100); end
    step();
    do_reprogram(2'd3, 4'd0);
    pulse_req(3'b100, 6'b11_00_00);
    step();
    step();
    checks++; if (timer_count !== 4'd10) begin errors++; $display("FAIL t3_count_default got=%0d exp=%0d", timer_count, 10); end
    cancel = 3'b100;
    step();
    cancel = '0;
    checks++; if (grant !== 3'b000 || busy !== 1'b0 || timer_count !== 4'd0 || expired !== 3'b000) begin
      errors++; $display("FAIL t3_abort got=g%b b%b c%0d e%b exp=g000 b0 c0 e000", grant, busy, timer_count, expired);
    end
  endtask

  task automatic test_restart();
    apply_reset();
    pulse_req(3'b001, 6'b00_00_00);
    step();
    step();
    for (int k = 0; k < 3; k++) tick();
    checks++; if (timer_count !== 4'd3) begin errors++; $display("FAIL t4_count3 got=%0d exp=%0d", timer_count, 3); end
    pulse_req(3'b001, 6'b00_00_01);
    checks++; if (timer_count !== 4'd8) begin errors++; $display("FAIL t4_reload got=%0d exp=%0d", timer_count, 8); end
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL t4_grant got=%b exp=%b", grant, 3'b001); end
    checks++; if (active_interval !== 2'd1) begin errors++; $display("FAIL t4_active got=%0d exp=%0d", active_interval, 1); end
    for (int k = 0; k < 7; k++) tick();
    checks++; if (timer_count !== 4'd1 || expired !== 3'b000) begin
      errors++; $display("FAIL t4_before_final got=c%0d e%b exp=c1 e000", timer_count, expired);
    end
    tick();
    checks++; if (expired !== 3'b001) begin errors++; $display("FAIL t4_expired got=%b exp=%b", expired, 3'b001); end
    step();
    step();
    checks++; if (grant !== 3'b000 || expired !== 3'b000) begin
      errors++; $display("FAIL t4_no_regrant got=g%b e%b exp=g000 e000", grant, expired);
    end
  endtask

  task automatic test_cancel_final_tick();
    apply_reset();
    pulse_req(3'b001, 6'b00_00_00);
    step();
    step();
    pulse_req(3'b010, 6'b00_01_00);
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL t5_owner_kept got=%b exp=%b", grant, 3'b001); end
    for (int k = 0; k < 5; k++) tick();
    checks++; if (timer_count !== 4'd1) begin errors++; $display("FAIL t5_count1 got=%0d exp=%0d", timer_count, 1); end
    cancel = 3'b001;
    one_hz_enable = 1'b1;
    step();
    cancel = '0;
    one_hz_enable = 1'b0;
    checks++; if (expired !== 3'b000) begin errors++; $display("FAIL t5_no_pulse got=%b exp=%b", expired, 3'b000); end
    checks++; if (grant !== 3'b000 || busy !== 1'b0 || timer_count !== 4'd0) begin
      errors++; $display("FAIL t5_idle got=g%b b%b c%0d exp=g000 b0 c0", grant, busy, timer_count);
    end
    step();
    checks++; if (expired !== 3'b000) begin errors++; $display("FAIL t5_no_late_pulse got=%b exp=%b", expired, 3'b000); end
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL t5_next_grant got=%b exp=%b", grant, 3'b010); end
    step();
    checks++; if (timer_count !== 4'd8) begin errors++; $display("FAIL t5_next_count got=%0d exp=%0d", timer_count, 8); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_reprogram(2'd1, 4'd3);
    pulse_req(3'b001, 6'b00_00_00);
    step();
    step();
    tick();
    pulse_req(3'b100, 6'b10_00_00);
    checks++; if (timer_count !== 4'd5) begin errors++; $display("FAIL t6_count5 got=%0d exp=%0d", timer_count, 5); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (grant !== 3'b000 || busy !== 1'b0 || timer_count !== 4'd0 || expired !== 3'b000 || active_interval !== 2'd0) begin
      errors++; $display("FAIL t6_async got=g%b b%b c%0d e%b a%0d exp=all zero", grant, busy, timer_count, expired, active_interval);
    end
    step();
    reset = 1'b0;
    step();
    step();
    step();
    checks++; if (grant !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL t6_pending_lost got=g%b b%b exp=g000 b0", grant, busy);
    end
    pulse_req(3'b010, 6'b00_01_00);
    step();
    step();
    checks++; if (timer_count !== 4'd8) begin errors++; $display("FAIL t6_table_restored got=%0d exp=%0d", timer_count, 8); end
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_round_robin();
    test_reprogram();
    test_restart();
    test_cancel_final_tick();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
